// File: rtl/rae_loader.sv
`timescale 1ns/1ps
// rae_loader: command-driven front end for the RAE core.
// LOAD commands pack a little-endian byte stream into 32-bit words and write
// them through port 0 of the weight or activation SRAM. RUN commands hand a
// configuration word to RAE, wait for it to finish and report its status.
// The loader owns SRAM port 0 whenever loader_busy is high.
module rae_loader #(
    parameter int ADDR_W = 16,
    parameter int CONF_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [CONF_W-1:0] cmd_conf,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,

    output logic              w_cen,
    output logic [3:0]        w_wea0,
    output logic [ADDR_W-1:0] w_addr0,
    output logic [31:0]       w_wdata0,

    output logic              a_cen,
    output logic [3:0]        a_wea0,
    output logic [ADDR_W-1:0] a_addr0,
    output logic [31:0]       a_wdata0,

    output logic [CONF_W-1:0] rae_conf,
    output logic              rae_valid,
    input  logic              rae_ready,
    input  logic [1:0]        rae_status,

    output logic              loader_busy,
    output logic              done,
    output logic [1:0]        done_status
);

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_RESERVED = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_REQ,
        RUN_WAIT_LO,
        RUN_WAIT_HI,
        DONE
    } state_t;

    state_t state;

    // Command fields captured at accept time.
    logic [1:0]        op_latched;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_len;

    // Byte packing state: byte position inside the current word, index of the
    // word being assembled, and the three lower bytes collected so far.
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       pack_word;

    logic              cmd_fire;
    logic              byte_fire;
    logic              word_fire;
    logic              last_word;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       write_word;

    // Handshake qualifiers and the address/data of the word completing this cycle.
    always_comb begin
        cmd_fire   = cmd_valid && cmd_ready && (state == IDLE);
        byte_fire  = in_valid && in_ready && (state == LOAD);
        word_fire  = byte_fire && (byte_idx == 2'd3);
        last_word  = (word_idx == (word_len - ADDR_ONE));
        write_addr = base_addr + word_idx;
        write_word = {in_data, pack_word};
    end

    // Control FSM: command intake, LOAD termination, RAE handshake and completion reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_latched  <= OP_LOAD_W;
            base_addr   <= '0;
            word_len    <= '0;
            cmd_ready   <= 1'b1;
            in_ready    <= 1'b0;
            rae_conf    <= '0;
            rae_valid   <= 1'b0;
            loader_busy <= 1'b0;
            done        <= 1'b0;
            done_status <= STATUS_OK;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        op_latched  <= cmd_op;
                        base_addr   <= cmd_base;
                        word_len    <= cmd_len;
                        cmd_ready   <= 1'b0;
                        loader_busy <= 1'b1;

                        case (cmd_op)
                            OP_LOAD_W, OP_LOAD_A: begin
                                if (cmd_len != '0) begin
                                    state    <= LOAD;
                                    in_ready <= 1'b1;
                                end else begin
                                    state       <= DONE;
                                    done        <= 1'b1;
                                    done_status <= STATUS_OK;
                                end
                            end
                            OP_RUN: begin
                                state     <= RUN_REQ;
                                rae_conf  <= cmd_conf;
                                rae_valid <= 1'b0;
                            end
                            default: begin
                                state       <= DONE;
                                done        <= 1'b1;
                                done_status <= STATUS_RESERVED;
                            end
                        endcase
                    end
                end

                LOAD: begin
                    // The final word's write and the done pulse land in the same cycle.
                    if (word_fire && last_word) begin
                        in_ready    <= 1'b0;
                        state       <= DONE;
                        done        <= 1'b1;
                        done_status <= STATUS_OK;
                    end
                end

                RUN_REQ: begin
                    // rae_valid tracks rae_ready so it is never offered to a busy RAE.
                    if (rae_valid && rae_ready) begin
                        rae_valid <= 1'b0;
                        state     <= RUN_WAIT_LO;
                    end else begin
                        rae_valid <= rae_ready;
                    end
                end

                RUN_WAIT_LO: begin
                    if (!rae_ready) begin
                        state <= RUN_WAIT_HI;
                    end
                end

                RUN_WAIT_HI: begin
                    if (rae_ready) begin
                        done_status <= rae_status;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b1;
                    loader_busy <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b1;
                    in_ready    <= 1'b0;
                    rae_valid   <= 1'b0;
                    loader_busy <= 1'b0;
                end
            endcase
        end
    end

    // Byte packer and SRAM port 0 drivers; a write strobe lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 2'd0;
            word_idx  <= '0;
            pack_word <= '0;
            w_cen     <= 1'b1;
            w_wea0    <= 4'h0;
            w_addr0   <= '0;
            w_wdata0  <= '0;
            a_cen     <= 1'b1;
            a_wea0    <= 4'h0;
            a_addr0   <= '0;
            a_wdata0  <= '0;
        end else begin
            w_cen  <= 1'b1;
            w_wea0 <= 4'h0;
            a_cen  <= 1'b1;
            a_wea0 <= 4'h0;

            if (cmd_fire) begin
                byte_idx <= 2'd0;
                word_idx <= '0;
            end else if (byte_fire) begin
                byte_idx  <= byte_idx + 2'd1;
                // Shifting in from the top leaves byte 0 in bits [7:0] after three bytes.
                pack_word <= {in_data, pack_word[23:8]};

                if (word_fire) begin
                    word_idx <= word_idx + ADDR_ONE;
                    if (op_latched == OP_LOAD_A) begin
                        a_cen    <= 1'b0;
                        a_wea0   <= 4'hF;
                        a_addr0  <= write_addr;
                        a_wdata0 <= write_word;
                    end else begin
                        w_cen    <= 1'b0;
                        w_wea0   <= 4'hF;
                        w_addr0  <= write_addr;
                        w_wdata0 <= write_word;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rae_loader.sv
`timescale 1ns/1ps
// tb_rae_loader: scoreboard bench for rae_loader. Expected SRAM writes and
// done statuses are queued when a command is issued and popped when the DUT
// produces them; each scenario task also checks its own timing inline.
module tb_rae_loader;

    localparam int ADDR_W = 16;
    localparam int CONF_W = 24;

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic PORT_W = 1'b0;
    localparam logic PORT_A = 1'b1;

    typedef struct packed {
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_len;
    logic [CONF_W-1:0] cmd_conf;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              w_cen;
    logic [3:0]        w_wea0;
    logic [ADDR_W-1:0] w_addr0;
    logic [31:0]       w_wdata0;
    logic              a_cen;
    logic [3:0]        a_wea0;
    logic [ADDR_W-1:0] a_addr0;
    logic [31:0]       a_wdata0;
    logic [CONF_W-1:0] rae_conf;
    logic              rae_valid;
    logic              rae_ready;
    logic [1:0]        rae_status;
    logic              loader_busy;
    logic              done;
    logic [1:0]        done_status;

    wr_t        exp_wr_q[$];
    logic [1:0] exp_status_q[$];
    wr_t        mon_exp;
    logic [1:0] mon_status;

    int checks      = 0;
    int errors      = 0;
    int writes_seen = 0;

    // Every output in one vector, compared against its reset image.
    logic [136:0] out_vec;
    assign out_vec = {cmd_ready, in_ready, w_cen, w_wea0, w_addr0, w_wdata0,
                      a_cen, a_wea0, a_addr0, a_wdata0, rae_conf, rae_valid,
                      loader_busy, done, done_status};

    localparam logic [136:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 32'h0000_0000,
                                          1'b1, 4'h0, 16'h0000, 32'h0000_0000, 24'h000000,
                                          1'b0, 1'b0, 1'b0, 2'b00};

    rae_loader #(
        .ADDR_W(ADDR_W),
        .CONF_W(CONF_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .cmd_conf   (cmd_conf),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .w_cen      (w_cen),
        .w_wea0     (w_wea0),
        .w_addr0    (w_addr0),
        .w_wdata0   (w_wdata0),
        .a_cen      (a_cen),
        .a_wea0     (a_wea0),
        .a_addr0    (a_addr0),
        .a_wdata0   (a_wdata0),
        .rae_conf   (rae_conf),
        .rae_valid  (rae_valid),
        .rae_ready  (rae_ready),
        .rae_status (rae_status),
        .loader_busy(loader_busy),
        .done       (done),
        .done_status(done_status)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: every SRAM write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!w_cen) begin
                writes_seen++;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_w unexpected: addr=%h data=%h wea=%h", w_addr0, w_wdata0, w_wea0);
                end else begin
                    mon_exp = exp_wr_q.pop_front();
                    if ({PORT_W, w_wea0, w_addr0, w_wdata0} !== {mon_exp.port, 4'hF, mon_exp.addr, mon_exp.data}) begin
                        errors++;
                        $display("[TB] FAIL write_w got port=W wea=%h addr=%h data=%h, want port=%0d wea=f addr=%h data=%h",
                                 w_wea0, w_addr0, w_wdata0, mon_exp.port, mon_exp.addr, mon_exp.data);
                    end
                end
            end
            if (!a_cen) begin
                writes_seen++;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_a unexpected: addr=%h data=%h wea=%h", a_addr0, a_wdata0, a_wea0);
                end else begin
                    mon_exp = exp_wr_q.pop_front();
                    if ({PORT_A, a_wea0, a_addr0, a_wdata0} !== {mon_exp.port, 4'hF, mon_exp.addr, mon_exp.data}) begin
                        errors++;
                        $display("[TB] FAIL write_a got port=A wea=%h addr=%h data=%h, want port=%0d wea=f addr=%h data=%h",
                                 a_wea0, a_addr0, a_wdata0, mon_exp.port, mon_exp.addr, mon_exp.data);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_status_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL done_unexpected: status=%b", done_status);
                end else begin
                    mon_status = exp_status_q.pop_front();
                    if (done_status !== mon_status) begin
                        errors++;
                        $display("[TB] FAIL done_status got=%b want=%b", done_status, mon_status);
                    end
                end
            end
        end
    end

    // Offer a command and return in the first cycle after it was accepted.
    task automatic issue_cmd(input logic [1:0] op, input logic [15:0] base,
                             input logic [15:0] len, input logic [23:0] conf);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        cmd_conf  = conf;
        while (!cmd_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("[TB] FAIL cmd_accept timeout: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Stream n consecutive byte values; returns in the cycle after the last accept.
    task automatic send_bytes(input int n, input logic [7:0] first, output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = first + 8'(i);
            guard    = 0;
            while (!in_ready && guard < 20) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_write(input logic port, input logic [15:0] addr, input logic [31:0] data);
        wr_t w;
        w.port = port;
        w.addr = addr;
        w.data = data;
        exp_wr_q.push_back(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_values got=%h want=%h", out_vec, RESET_VEC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got=%h want=%h", out_vec, RESET_VEC);
        end
    endtask

    task automatic test_load_w();
        int stalls;
        int base_writes;
        base_writes = writes_seen;
        push_write(PORT_W, 16'h0010, 32'h0403_0201);
        push_write(PORT_W, 16'h0011, 32'h0807_0605);
        exp_status_q.push_back(2'b00);
        issue_cmd(OP_LOAD_W, 16'h0010, 16'h0002, 24'h0);
        checks++;
        if ({in_ready, cmd_ready, loader_busy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL load_w_entry got in_ready/cmd_ready/busy=%b want 101", {in_ready, cmd_ready, loader_busy});
        end
        send_bytes(8, 8'h01, stalls);
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("[TB] FAIL load_w_stalls got=%0d want 0", stalls);
        end
        checks++;
        if ({in_ready, done, cmd_ready, loader_busy} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL load_w_done_cycle got in_ready/done/cmd_ready/busy=%b want 0101",
                     {in_ready, done, cmd_ready, loader_busy});
        end
        @(negedge clk);
        checks++;
        if ({done, cmd_ready, loader_busy, done_status} !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL load_w_back_to_idle got done/cmd_ready/busy/status=%b want 01000",
                     {done, cmd_ready, loader_busy, done_status});
        end
        checks++;
        if (writes_seen - base_writes !== 2) begin
            errors++;
            $display("[TB] FAIL load_w_write_count got=%0d want 2", writes_seen - base_writes);
        end
    endtask

    task automatic test_load_a_wrap();
        int stalls;
        int base_writes;
        base_writes = writes_seen;
        push_write(PORT_A, 16'hFFFF, 32'h1413_1211);
        push_write(PORT_A, 16'h0000, 32'h1817_1615);
        exp_status_q.push_back(2'b00);
        issue_cmd(OP_LOAD_A, 16'hFFFF, 16'h0002, 24'h0);
        send_bytes(8, 8'h11, stalls);
        checks++;
        if ({in_ready, done} !== 2'b01 || stalls !== 0) begin
            errors++;
            $display("[TB] FAIL load_a_wrap_end got in_ready/done=%b stalls=%0d want 01 stalls=0", {in_ready, done}, stalls);
        end
        @(negedge clk);
        checks++;
        if (writes_seen - base_writes !== 2) begin
            errors++;
            $display("[TB] FAIL load_a_wrap_write_count got=%0d want 2", writes_seen - base_writes);
        end
    endtask

    task automatic test_zero_len_and_reserved();
        int base_writes;
        base_writes = writes_seen;
        exp_status_q.push_back(2'b00);
        issue_cmd(OP_LOAD_A, 16'h1234, 16'h0000, 24'h0);
        checks++;
        if ({done, in_ready, w_cen, a_cen} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL zero_len_done got done/in_ready/w_cen/a_cen=%b want 1011", {done, in_ready, w_cen, a_cen});
        end
        @(negedge clk);
        checks++;
        if ({done, cmd_ready, loader_busy} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL zero_len_idle got done/cmd_ready/busy=%b want 010", {done, cmd_ready, loader_busy});
        end

        exp_status_q.push_back(2'b11);
        issue_cmd(OP_RSVD, 16'h0000, 16'h0005, 24'h0);
        checks++;
        if ({done, in_ready, w_cen, a_cen} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL reserved_done got done/in_ready/w_cen/a_cen=%b want 1011", {done, in_ready, w_cen, a_cen});
        end
        @(negedge clk);
        checks++;
        if ({done, done_status} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL reserved_status_hold got done/status=%b want 011", {done, done_status});
        end
        checks++;
        if (writes_seen !== base_writes) begin
            errors++;
            $display("[TB] FAIL zero_len_no_write got=%0d writes want 0", writes_seen - base_writes);
        end
    endtask

    task automatic test_run();
        int   guard;
        logic early_valid;
        logic extra_valid;
        logic bad_in_ready;
        logic early_done;
        early_valid  = 1'b0;
        extra_valid  = 1'b0;
        bad_in_ready = 1'b0;
        early_done   = 1'b0;
        rae_ready    = 1'b0;
        rae_status   = 2'b00;
        exp_status_q.push_back(2'b01);
        issue_cmd(OP_RUN, 16'h0000, 16'h0000, 24'hABCDEF);

        // RAE still busy for three cycles; bytes toggled on the input are ignored.
        for (int i = 0; i < 3; i++) begin
            if (rae_valid) early_valid = 1'b1;
            if (in_ready) bad_in_ready = 1'b1;
            in_data  = 8'hEE;
            in_valid = ~in_valid;
            @(negedge clk);
        end
        checks++;
        if (early_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_valid_before_ready got=%b want 0", early_valid);
        end

        rae_ready = 1'b1;
        guard = 0;
        while (!rae_valid && guard < 10) begin
            if (in_ready) bad_in_ready = 1'b1;
            in_valid = ~in_valid;
            guard++;
            @(negedge clk);
        end
        checks++;
        if ({rae_valid, rae_conf} !== {1'b1, 24'hABCDEF}) begin
            errors++;
            $display("[TB] FAIL run_request got valid=%b conf=%h want valid=1 conf=abcdef", rae_valid, rae_conf);
        end

        // Handshake completes on this edge; RAE then goes busy for ten cycles.
        @(negedge clk);
        rae_ready = 1'b0;
        checks++;
        if (rae_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_valid_drop got=%b want 0", rae_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (rae_valid) extra_valid = 1'b1;
            if (done) early_done = 1'b1;
            if (in_ready) bad_in_ready = 1'b1;
            in_valid = ~in_valid;
            @(negedge clk);
        end
        in_valid   = 1'b0;
        rae_ready  = 1'b1;
        rae_status = 2'b01;

        guard = 0;
        while (!done && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (guard !== 1 || done_status !== 2'b01) begin
            errors++;
            $display("[TB] FAIL run_done got latency=%0d status=%b want latency=1 status=01", guard, done_status);
        end
        @(negedge clk);
        checks++;
        if ({done, done_status, cmd_ready, loader_busy} !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL run_done_pulse got done/status/cmd_ready/busy=%b want 00110",
                     {done, done_status, cmd_ready, loader_busy});
        end
        checks++;
        if ({extra_valid, early_done, bad_in_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL run_quiet got extra_valid/early_done/in_ready_seen=%b want 000",
                     {extra_valid, early_done, bad_in_ready});
        end
        rae_status = 2'b00;
    endtask

    task automatic test_load_after_run();
        int stalls;
        push_write(PORT_W, 16'h0040, 32'hA4A3_A2A1);
        exp_status_q.push_back(2'b00);
        issue_cmd(OP_LOAD_W, 16'h0040, 16'h0001, 24'h0);
        send_bytes(4, 8'hA1, stalls);
        checks++;
        if ({in_ready, done, done_status} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL load_after_run_done got in_ready/done/status=%b want 0100", {in_ready, done, done_status});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int stalls;
        push_write(PORT_A, 16'h0020, 32'h3433_3231);
        issue_cmd(OP_LOAD_A, 16'h0020, 16'h0002, 24'h0);
        send_bytes(6, 8'h31, stalls);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_mid_load got=%h want=%h", out_vec, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push_write(PORT_A, 16'h0050, 32'h4443_4241);
        exp_status_q.push_back(2'b00);
        issue_cmd(OP_LOAD_A, 16'h0050, 16'h0001, 24'h0);
        send_bytes(4, 8'h41, stalls);
        checks++;
        if ({in_ready, done} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reload_after_reset got in_ready/done=%b want 01", {in_ready, done});
        end
        @(negedge clk);
    endtask

    // Scenario sequence followed by the drain checks and the summary.
    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_base   = '0;
        cmd_len    = '0;
        cmd_conf   = '0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        rae_ready  = 1'b1;
        rae_status = 2'b00;

        test_reset();
        test_load_w();
        test_load_a_wrap();
        test_zero_len_and_reserved();
        test_run();
        test_load_after_run();
        test_reset_mid_load();

        repeat (2) @(negedge clk);
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL writes_outstanding got=%0d want 0", exp_wr_q.size());
        end
        checks++;
        if (exp_status_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL dones_outstanding got=%0d want 0", exp_status_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rae_loader.md
Name: rae_loader

Overview:
- Command-driven front end that sits directly upstream of the RAE core.
- Packs a host byte stream into 32-bit words and writes them through port 0 of the weight or activation dual-port SRAM.
- On a RUN command, hands a 24-bit configuration to RAE over its valid/ready handshake, waits for completion and returns RAE's status.
- While rae_loader is busy it owns SRAM port 0; the top-level mux selects it on loader_busy.

Parameters:
- ADDR_W, 16: SRAM word-address width.
- CONF_W, 24: RAE configuration width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 LOAD_W, 01 LOAD_A, 10 RUN, 11 reserved.
- cmd_base  in  ADDR_W  first word address (LOAD only).
- cmd_len  in  ADDR_W  word count (LOAD only).
- cmd_conf  in  CONF_W  RAE configuration (RUN only).
- in_valid  in  1  byte offered.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- in_data  in  8  byte.
- w_cen  out  1  weight SRAM chip enable, active-low.
- w_wea0  out  4  weight byte write enables.
- w_addr0  out  ADDR_W  weight address.
- w_wdata0  out  32  weight write data.
- a_cen, a_wea0, a_addr0, a_wdata0  out  1/4/ADDR_W/32  activation SRAM equivalents.
- rae_conf  out  CONF_W  to RAE conf.
- rae_valid  out  1  to RAE valid.
- rae_ready  in  1  from RAE ready; high = RAE idle.
- rae_status  in  2  from RAE status.
- loader_busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  result; held until the next done.

Behaviour:
- Reset values, all outputs: cmd_ready=1, in_ready=0, w_cen=a_cen=1, wea=0, addr=0, wdata=0, rae_conf=0, rae_valid=0, loader_busy=0, done=0, done_status=0.
- Reset asserted mid-operation aborts immediately to IDLE with reset values; partially packed bytes are discarded.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN_REQ, RUN_WAIT_LO, RUN_WAIT_HI, DONE.
- IDLE: cmd_ready=1. On accept, latch base/len/conf/op, then:
  - LOAD_W or LOAD_A with len>0 -> LOAD.
  - LOAD with len=0 -> DONE, status 00.
  - RUN -> RUN_REQ.
  - op 11 -> DONE, status 11.
- cmd_ready=0 in every state other than IDLE.
- LOAD: in_ready=1. Bytes pack little-endian: byte k of the word goes to bits [8k+7:8k].
  - The cycle after the 4th byte is accepted, the selected SRAM port shows cen=0, wea=4'hF, addr=base+word_idx, wdata=the packed word, for exactly one cycle.
  - The other SRAM's cen stays 1.
  - in_ready stays high through the write cycle; bytes are never stalled.
  - Address arithmetic is modulo 2^ADDR_W; base+idx wraps past 0xFFFF to 0x0000.
  - After the len-th word is accepted, in_ready drops the next cycle. The FSM then goes to DONE, with the final write issued in that same cycle. status=00.
- RUN_REQ:
  - rae_conf=latched conf; rae_valid=1 while rae_ready=1.
  - Transfer occurs on rae_valid & rae_ready, then -> RUN_WAIT_LO; rae_valid deasserts the following cycle.
  - If rae_ready=0 on entry, rae_valid stays 0 until rae_ready=1.
- RUN_WAIT_LO: wait for rae_ready=0 -> RUN_WAIT_HI.
- RUN_WAIT_HI: wait for rae_ready=1. Capture rae_status into done_status in that cycle -> DONE.
- DONE: done=1 for one cycle -> IDLE. done_status is updated the same cycle done rises.
- in_valid outside LOAD is ignored: in_ready=0, nothing is consumed.

Test Plan:
- Reset mid-LOAD after 6 bytes -> all outputs return to reset values; the next LOAD starts packing at byte 0.
- LOAD_W base=0x0010 len=2, bytes 01..08 back-to-back:
  - weight writes addr 0x0010 data 0x04030201, then addr 0x0011 data 0x08070605.
  - wea=F on each write; a_cen stays 1.
  - done=1 with done_status=00; 8 bytes consumed, no stalls.
- LOAD_A base=0xFFFF len=2 -> activation writes at 0xFFFF then 0x0000; in_ready falls after byte 8.
- LOAD len=0, and op=11 -> done the cycle after accept; done_status 00 and 11 respectively; no SRAM access.
- RUN conf=0xABCDEF with rae_ready low 3 cycles, then high:
  - rae_valid rises only once rae_ready=1; RAE pulls ready low for 10 cycles, then high with status=01.
  - done_status=01, done one cycle.
- in_valid toggled during RUN -> in_ready=0, no bytes consumed; a following LOAD starts packing at byte 0.
